led_status_driver: RTL



---
 rtl/led_status_pkg.sv | 15 +
 rtl/led_stretch_ch.sv | 64 ++++++
 rtl/led_status_driver.sv | 79 +++++++
 3 files changed

// File: rtl/led_status_pkg.sv
// Shared types and sizing helpers for the LED status driver.
package led_status_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } led_state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One LED channel: OFF/ON/HOLD pulse stretcher with its own tick-based hold counter.
module led_stretch_ch
    import led_status_pkg::*;
#(
    parameter int unsigned STRETCH_TICKS = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic led_in,
    input  logic tick,
    output logic active
);

    localparam int unsigned     HW    = cnt_width(STRETCH_TICKS + 1);
    localparam logic [HW-1:0]   HLOAD = HW'(STRETCH_TICKS);

    led_state_t     r_state;
    led_state_t     w_state_nxt;
    logic [HW-1:0]  r_hcnt;
    logic [HW-1:0]  w_hcnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_OFF;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        unique case (r_state)
            ST_OFF: begin
                if (led_in) w_state_nxt = ST_ON;
            end
            ST_ON: begin
                if (!led_in) begin
                    if (STRETCH_TICKS == 0) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_hcnt_nxt  = HLOAD;
                    end
                end
            end
            ST_HOLD: begin
                // A re-asserted request wins over a tick landing in the same cycle.
                if (led_in) begin
                    w_state_nxt = ST_ON;
                end else if (tick) begin
                    if (r_hcnt == HW'(1)) w_state_nxt = ST_OFF;
                    else                  w_hcnt_nxt  = r_hcnt - HW'(1);
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    assign active = (r_state != ST_OFF);

endmodule

// File: rtl/led_status_driver.sv
// LED pin driver: per-LED pulse stretch, global PWM dimming and optional blinking.
module led_status_driver
    import led_status_pkg::*;
#(
    parameter int unsigned LED_W         = 8,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned STRETCH_TICKS = 50,
    parameter int unsigned BLINK_TICKS   = 250,
    parameter int unsigned PWM_BITS      = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [LED_W-1:0]    led_in,
    input  logic [LED_W-1:0]    blink_en,
    input  logic [PWM_BITS-1:0] dim_level,
    output logic [LED_W-1:0]    led_out,
    output logic                tick
);

    localparam int unsigned   PW         = cnt_width(TICK_DIV);
    localparam int unsigned   BW         = cnt_width(BLINK_TICKS);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [PW-1:0]       r_pre_cnt;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink_ph;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [LED_W-1:0]    r_led_out;
    logic                w_tick;
    logic                w_pwm_on;
    logic [LED_W-1:0]    w_active;
    logic [LED_W-1:0]    w_lit;

    assign w_tick   = (r_pre_cnt == PRE_LAST);
    assign w_pwm_on = (r_pwm_cnt < dim_level);
    assign w_lit    = w_active & {LED_W{w_pwm_on}} & (~blink_en | {LED_W{r_blink_ph}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt   <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
            r_pwm_cnt   <= '0;
            r_led_out   <= ACTIVE_LOW ? '1 : '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_tick) begin
                r_pre_cnt <= '0;
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink_ph  <= ~r_blink_ph;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end else begin
                r_pre_cnt <= r_pre_cnt + PW'(1);
            end
            r_led_out <= ACTIVE_LOW ? ~w_lit : w_lit;
        end
    end

    for (genvar g = 0; g < LED_W; g++) begin : g_ch
        led_stretch_ch #(
            .STRETCH_TICKS (STRETCH_TICKS)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .led_in  (led_in[g]),
            .tick    (w_tick),
            .active  (w_active[g])
        );
    end

    assign led_out = r_led_out;
    assign tick    = w_tick;

endmodule
